// File: rtl/shift_arbiter_pkg.sv
// Shared encodings and widths for the two-requester shift arbiter.
package shift_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_t;

    localparam logic ID_ALU = 1'b0;
    localparam logic ID_MD  = 1'b1;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MD  = 1'b1
    } grant_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request and response handshake bundle between requesters/consumer and the arbiter.
interface shift_arbiter_if;
    import shift_arbiter_pkg::*;

    logic               req0_valid;
    logic               req0_ready;
    logic [1:0]         req0_op;
    logic [DATA_W-1:0]  req0_data;
    logic [SHAMT_W-1:0] req0_shamt;

    logic               req1_valid;
    logic               req1_ready;
    logic [1:0]         req1_op;
    logic [DATA_W-1:0]  req1_data;
    logic [SHAMT_W-1:0] req1_shamt;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_data;
    logic               rsp_id;

    modport master (
        output req0_valid, req0_op, req0_data, req0_shamt,
        output req1_valid, req1_op, req1_data, req1_shamt,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_op, req0_data, req0_shamt,
        input  req1_valid, req1_op, req1_data, req1_shamt,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/shift_arbiter_shift_core.sv
// Combinational 32-bit shifter: logical left/right, arithmetic right, or pass-through.
module shift_core
    import shift_arbiter_pkg::*;
(
    input  op_t                op,
    input  logic [DATA_W-1:0]  data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [DATA_W-1:0]  result
);

    logic [DATA_W-1:0] sll_res;
    logic [DATA_W-1:0] srl_res;
    logic [DATA_W-1:0] sra_res;

    assign sll_res = data << shamt;
    assign srl_res = data >> shamt;
    assign sra_res = $unsigned($signed(data) >>> shamt);

    always_comb begin
        result = data;
        case (op)
            OP_SLL:  result = sll_res;
            OP_SRL:  result = srl_res;
            OP_SRA:  result = sra_res;
            OP_PASS: result = data;
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between ALU issue (req0) and multdiv (req1).
//
//   state      | meaning
//   GRANT_ALU  | req0 took the last transfer, req1 wins the next conflict
//   GRANT_MD   | req1 took the last transfer, req0 wins the next conflict
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int STALL_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    shift_arbiter_if.slave     bus,
    output logic [STALL_W-1:0] stall_cnt
);

    grant_t            last_grant;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_id_q;

    logic               accept;
    logic               grant0;
    logic               grant1;
    logic               stalled;
    op_t                sel_op;
    logic [DATA_W-1:0]  sel_data;
    logic [SHAMT_W-1:0] sel_shamt;
    logic [DATA_W-1:0]  shift_res;

    // A draining response frees the register in the same cycle, giving full throughput.
    assign accept         = ~rsp_valid_q | bus.rsp_ready;
    assign bus.req0_ready = accept & (~bus.req1_valid | (last_grant == GRANT_MD));
    assign bus.req1_ready = accept & (~bus.req0_valid | (last_grant == GRANT_ALU));

    assign grant0  = bus.req0_valid & bus.req0_ready;
    assign grant1  = bus.req1_valid & bus.req1_ready;
    assign stalled = (bus.req0_valid & ~bus.req0_ready) | (bus.req1_valid & ~bus.req1_ready);

    assign sel_op    = grant1 ? op_t'(bus.req1_op) : op_t'(bus.req0_op);
    assign sel_data  = grant1 ? bus.req1_data      : bus.req0_data;
    assign sel_shamt = grant1 ? bus.req1_shamt     : bus.req0_shamt;

    shift_core u_shift_core (
        .op     (sel_op),
        .data   (sel_data),
        .shamt  (sel_shamt),
        .result (shift_res)
    );

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant  <= GRANT_MD;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= ID_ALU;
            stall_cnt   <= '0;
        end else begin
            if (grant0 | grant1) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= shift_res;
                rsp_id_q    <= grant1 ? ID_MD : ID_ALU;
                last_grant  <= grant1 ? GRANT_MD : GRANT_ALU;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (stalled && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and random checks of shift_arbiter against a transaction-level reference model.
module tb_shift_arbiter;

    logic        clock;
    logic        reset;
    logic [15:0] stall_cnt;
    int          total = 0;
    int          bad   = 0;

    shift_arbiter_if ifc ();

    shift_arbiter #(.STALL_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (ifc),
        .stall_cnt (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_id;
    int          m_prefer;
    int          m_stall;
    bit          last_r0, last_r1;

    task automatic model_reset();
        m_valid  = 0;
        m_data   = 32'h0;
        m_id     = 0;
        m_prefer = 0;
        m_stall  = 0;
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                              input logic [4:0] sh);
        int unsigned n;
        logic [31:0] r;
        n = sh;
        case (op)
            2'd0: r = d << n;
            2'd1: r = d >> n;
            2'd2: begin
                r = d;
                for (int k = 0; k < n; k++) r = {d[31], r[31:1]};
            end
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step();
        bit acc, r0, r1, g0, g1;
        #1;
        acc = !m_valid || ifc.rsp_ready;
        r0  = acc && (!ifc.req1_valid || m_prefer == 0);
        r1  = acc && (!ifc.req0_valid || m_prefer == 1);
        chk("req0_ready", {31'b0, ifc.req0_ready}, {31'b0, r0});
        chk("req1_ready", {31'b0, ifc.req1_ready}, {31'b0, r1});
        g0 = ifc.req0_valid && r0;
        g1 = ifc.req1_valid && r1;
        if ((ifc.req0_valid && !r0) || (ifc.req1_valid && !r1))
            m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        if (g0) begin
            m_data = ref_shift(ifc.req0_op, ifc.req0_data, ifc.req0_shamt);
            m_id = 0; m_valid = 1; m_prefer = 1;
        end else if (g1) begin
            m_data = ref_shift(ifc.req1_op, ifc.req1_data, ifc.req1_shamt);
            m_id = 1; m_valid = 1; m_prefer = 0;
        end else if (ifc.rsp_ready) begin
            m_valid = 0;
        end
        last_r0 = r0;
        last_r1 = r1;
        @(posedge clock);
        #1;
        chk("rsp_valid", {31'b0, ifc.rsp_valid}, {31'b0, m_valid});
        chk("rsp_id",    {31'b0, ifc.rsp_id},    {31'b0, m_id});
        chk("rsp_data",  ifc.rsp_data, m_data);
        chk("stall_cnt", {16'b0, stall_cnt}, m_stall);
    endtask

    task automatic idle_inputs();
        ifc.req0_valid = 0; ifc.req0_op = 0; ifc.req0_data = 0; ifc.req0_shamt = 0;
        ifc.req1_valid = 0; ifc.req1_op = 0; ifc.req1_data = 0; ifc.req1_shamt = 0;
        ifc.rsp_ready  = 1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(negedge clock);
        reset = 0;
        model_reset();
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        #1;
    endtask

    task automatic set_req0(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        ifc.req0_valid = 1; ifc.req0_op = op; ifc.req0_data = d; ifc.req0_shamt = sh;
    endtask

    task automatic set_req1(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
        ifc.req1_valid = 1; ifc.req1_op = op; ifc.req1_data = d; ifc.req1_shamt = sh;
    endtask

    logic [0:3] conflict_ids;

    initial begin
        reset = 0;
        idle_inputs();
        model_reset();
        #12;
        chk("reset_rsp_valid", {31'b0, ifc.rsp_valid}, 32'd0);
        chk("reset_rsp_data",  ifc.rsp_data, 32'd0);
        chk("reset_stall",     {16'b0, stall_cnt}, 32'd0);
        reset = 1;
        @(posedge clock);
        #1;

        // Single requester shifts
        set_req0(2'b10, 32'h8000_0000, 5'd4);
        step();
        chk("sra_const", ifc.rsp_data, 32'hF800_0000);
        set_req0(2'b01, 32'h8000_0000, 5'd4);
        step();
        chk("srl_const", ifc.rsp_data, 32'h0800_0000);
        set_req0(2'b00, 32'h0000_0001, 5'd31);
        step();
        chk("sll_const", ifc.rsp_data, 32'h8000_0000);
        ifc.req0_valid = 0;
        step();

        // Conflict alternation from a fresh reset
        apply_reset();
        set_req0(2'b11, 32'hAAAA_0000, 5'd0);
        set_req1(2'b11, 32'h0000_5555, 5'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            conflict_ids[i] = ifc.rsp_id;
        end
        chk("conflict_ids", {28'b0, conflict_ids}, 32'b0101);
        chk("conflict_stall", {16'b0, stall_cnt}, 32'd4);

        // Backpressure hold with pass-through
        idle_inputs();
        set_req1(2'b11, 32'h1234_5678, 5'd17);
        step();
        ifc.rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_data", ifc.rsp_data, 32'h1234_5678);
        end
        ifc.rsp_ready = 1;
        step();
        set_req1(2'b00, 32'h0000_0003, 5'd4);
        step();
        chk("no_bubble", {31'b0, ifc.rsp_valid}, 32'd1);

        // Lone req1 granted every cycle
        idle_inputs();
        for (int i = 1; i <= 3; i++) begin
            set_req1(2'b01, 32'hFFFF_FFFF, 5'(i));
            step();
        end
        chk("srl_lone", ifc.rsp_data, 32'h1FFF_FFFF);

        // Async reset with a stuck response
        idle_inputs();
        set_req0(2'b00, 32'h0000_00F0, 5'd2);
        step();
        idle_inputs();
        ifc.rsp_ready = 0;
        set_req1(2'b00, 32'h1, 5'd1);
        step();
        #2;
        reset = 0;
        #1;
        chk("async_rsp_valid", {31'b0, ifc.rsp_valid}, 32'd0);
        chk("async_stall", {16'b0, stall_cnt}, 32'd0);
        model_reset();
        idle_inputs();
        #1;
        reset = 1;
        @(posedge clock);
        #1;
        set_req0(2'b11, 32'h0BAD_F00D, 5'd3);
        set_req1(2'b11, 32'h0000_0001, 5'd3);
        step();
        chk("post_reset_grant", {31'b0, ifc.rsp_id}, 32'd0);

        // Random traffic; refused requesters hold their fields
        idle_inputs();
        last_r0 = 1; last_r1 = 1;
        for (int i = 0; i < 400; i++) begin
            if (!(ifc.req0_valid && !last_r0)) begin
                ifc.req0_valid = ($urandom_range(0, 3) != 0);
                ifc.req0_op    = 2'($urandom_range(0, 3));
                ifc.req0_data  = $urandom;
                ifc.req0_shamt = 5'($urandom_range(0, 31));
            end
            if (!(ifc.req1_valid && !last_r1)) begin
                ifc.req1_valid = ($urandom_range(0, 3) != 0);
                ifc.req1_op    = 2'($urandom_range(0, 3));
                ifc.req1_data  = $urandom;
                ifc.req1_shamt = 5'($urandom_range(0, 31));
            end
            ifc.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Stall counter saturation behind a stuck response
        apply_reset();
        set_req0(2'b00, 32'h1, 5'd1);
        step();
        idle_inputs();
        ifc.rsp_ready = 0;
        set_req1(2'b01, 32'h8000_0000, 5'd1);
        for (int i = 0; i < 65540; i++) step();
        chk("stall_saturated", {16'b0, stall_cnt}, 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
